// File: rtl/axi_lite_pkg.sv
// ============================================================================
//  Module   : axi_lite_pkg
//  Brief    : Shared AXI4-Lite response codes and register-map offsets for
//             the register slave.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

   // AXI response encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Register map (byte offsets, word aligned)
   localparam int          NUM_RW_REGS  = 6;
   localparam logic [11:0] OFF_REG0     = 12'h000;
   localparam logic [11:0] OFF_REG5     = 12'h014;
   localparam logic [11:0] OFF_ID       = 12'h018;
   localparam logic [11:0] OFF_WR_COUNT = 12'h01C;

   // Rebuild an aligned byte offset from the decoded word index ADDR[11:2]
   function automatic logic [11:0] word_offset(input logic [9:0] word_idx);
      return {word_idx, 2'b00};
   endfunction

   // True for offsets that land on one of the read/write registers
   function automatic logic is_rw_offset(input logic [11:0] off);
      return (off >= OFF_REG0) && (off <= OFF_REG5);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
// ============================================================================
//  Module   : axi_lite_reg_slave
//  Brief    : AXI4-Lite register slave: six byte-strobed RW registers, a
//             read-only ID word and a read-only count of successful writes.
//             Independent read and write state machines, one outstanding
//             transaction per direction, READY/VALID driven from state only.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_reg_slave
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] ID_VALUE    = 32'h5043_3201,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic          aclk,
   input  logic          aresetn,
   // write address channel
   input  logic [31:0]   S_AWADDR,
   input  logic [2:0]    S_AWPROT,
   input  logic          S_AWVALID,
   output logic          S_AWREADY,
   // write data channel
   input  logic [31:0]   S_WDATA,
   input  logic [3:0]    S_WSTRB,
   input  logic          S_WVALID,
   output logic          S_WREADY,
   // write response channel
   output logic [1:0]    S_BRESP,
   output logic          S_BVALID,
   input  logic          S_BREADY,
   // read address channel
   input  logic [31:0]   S_ARADDR,
   input  logic [2:0]    S_ARPROT,
   input  logic          S_ARVALID,
   output logic          S_ARREADY,
   // read data channel
   output logic [31:0]   S_RDATA,
   output logic [1:0]    S_RRESP,
   output logic          S_RVALID,
   input  logic          S_RREADY,
   // register contents
   output logic [191:0]  REG_O
);

   // Write FSM encoding
   localparam logic [1:0] W_IDLE    = 2'd0;
   localparam logic [1:0] W_HAVE_AW = 2'd1;
   localparam logic [1:0] W_HAVE_W  = 2'd2;
   localparam logic [1:0] W_RESP    = 2'd3;

   // Read FSM encoding
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   logic [1:0]                   w_state_q, w_state_d;
   logic [11:0]                  awaddr_q, awaddr_d;
   logic [31:0]                  wdata_q, wdata_d;
   logic [3:0]                   wstrb_q, wstrb_d;
   logic [1:0]                   bresp_q, bresp_d;
   logic [NUM_RW_REGS-1:0][31:0] regs_q, regs_d;
   logic [31:0]                  wr_count_q, wr_count_d;

   logic [0:0]                   r_state_q, r_state_d;
   logic [31:0]                  rdata_q, rdata_d;
   logic [1:0]                   rresp_q, rresp_d;

   logic                         aw_hs, w_hs, w_commit;
   logic [11:0]                  commit_off, rd_off;
   logic [31:0]                  commit_data;
   logic [3:0]                   commit_strb;

   // Address bits outside the local decode window and PROT are not used
   logic unused_inputs;
   assign unused_inputs = ^{S_AWADDR[31:12], S_AWADDR[1:0], S_AWPROT,
                            S_ARADDR[31:12], S_ARADDR[1:0], S_ARPROT};

   // Handshake flags and outputs, all derived from state flops only
   assign S_AWREADY = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
   assign S_WREADY  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
   assign S_BVALID  = (w_state_q == W_RESP);
   assign S_BRESP   = bresp_q;
   assign S_ARREADY = (r_state_q == R_IDLE);
   assign S_RVALID  = (r_state_q == R_DATA);
   assign S_RDATA   = rdata_q;
   assign S_RRESP   = rresp_q;
   assign REG_O     = regs_q;

   assign aw_hs = S_AWVALID && S_AWREADY;
   assign w_hs  = S_WVALID  && S_WREADY;

   // The half arriving on the commit edge comes straight from the bus; the
   // half that arrived earlier comes from the capture registers.
   assign commit_off  = aw_hs ? word_offset(S_AWADDR[11:2]) : awaddr_q;
   assign commit_data = w_hs  ? S_WDATA : wdata_q;
   assign commit_strb = w_hs  ? S_WSTRB : wstrb_q;
   assign rd_off      = word_offset(S_ARADDR[11:2]);

   // Write FSM next state; flags the edge that enters W_RESP as the commit
   always_comb begin
      w_state_d = w_state_q;
      w_commit  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               w_state_d = W_RESP;
               w_commit  = 1'b1;
            end else if (aw_hs) begin
               w_state_d = W_HAVE_AW;
            end else if (w_hs) begin
               w_state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            if (w_hs) begin
               w_state_d = W_RESP;
               w_commit  = 1'b1;
            end
         end
         W_HAVE_W: begin
            if (aw_hs) begin
               w_state_d = W_RESP;
               w_commit  = 1'b1;
            end
         end
         W_RESP: begin
            if (S_BREADY) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Hold whichever write half has been accepted until the other one arrives
   always_comb begin
      awaddr_d = aw_hs ? word_offset(S_AWADDR[11:2]) : awaddr_q;
      wdata_d  = w_hs  ? S_WDATA : wdata_q;
      wstrb_d  = w_hs  ? S_WSTRB : wstrb_q;
   end

   // Register commit with byte strobes, response code and write counter
   always_comb begin
      regs_d     = regs_q;
      wr_count_d = wr_count_q;
      bresp_d    = bresp_q;
      if (w_commit) begin
         if (is_rw_offset(commit_off)) begin
            bresp_d    = RESP_OKAY;
            wr_count_d = wr_count_q + 32'd1;
            for (int i = 0; i < NUM_RW_REGS; i++) begin
               if (commit_off[11:2] == 10'(i)) begin
                  for (int b = 0; b < 4; b++) begin
                     if (commit_strb[b]) begin
                        regs_d[i][b*8 +: 8] = commit_data[b*8 +: 8];
                     end
                  end
               end
            end
         end else begin
            bresp_d = RESP_SLVERR;
         end
      end
   end

   // Read FSM: capture data and response on the AR handshake edge
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (S_ARVALID) begin
               r_state_d = R_DATA;
               rresp_d   = RESP_OKAY;
               rdata_d   = 32'h0;
               if (is_rw_offset(rd_off)) begin
                  for (int i = 0; i < NUM_RW_REGS; i++) begin
                     if (rd_off[11:2] == 10'(i)) begin
                        rdata_d = regs_q[i];
                     end
                  end
               end else if (rd_off == OFF_ID) begin
                  rdata_d = ID_VALUE;
               end else if (rd_off == OFF_WR_COUNT) begin
                  rdata_d = wr_count_q;
               end else begin
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         R_DATA: begin
            if (S_RREADY) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write-side state, capture and register storage
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q  <= W_IDLE;
         awaddr_q   <= 12'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         bresp_q    <= RESP_OKAY;
         regs_q     <= {NUM_RW_REGS{RESET_VALUE}};
         wr_count_q <= 32'h0;
      end else begin
         w_state_q  <= w_state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         regs_q     <= regs_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Read-side state and captured response
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q <= R_IDLE;
         rdata_q   <= 32'h0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

endmodule

`default_nettype wire
